combine_job_scheduler: RTL and testbench

- Queues per-code-block HARQ combine jobs (user index, E01 size, Ncb size) for one slot and issues them one at a time to the FSM_Combine datapath.
- Holds each job's configuration stable for the whole combine, and counts completions.
- Signals slot completion and flags configuration and protocol errors.
- Sits between the slot/user configuration logic and FSM_Combine; it drives i_Combine_process_request, i_Combine_user_index, i_Current_Combine_E01_Size and i_Current_Combine_Ncb_Size, and consumes o_current_cb_combine_comp.

---
 rtl/combine_job_scheduler_pkg.sv | 29 ++
 rtl/combine_job_scheduler_if.sv | 22 ++
 rtl/combine_job_scheduler_fifo.sv | 57 +++++
 rtl/combine_job_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_combine_job_scheduler.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/combine_job_scheduler_pkg.sv
// Shared types and constants for the HARQ combine job scheduler.
// Optional watchdog feature is controlled by the COMBINE_WATCHDOG_EN macro.
package comb_sched_pkg;

  localparam int unsigned USER_W       = 4;
  localparam int unsigned E01_W        = 14;
  localparam int unsigned NCB_W        = 16;
  localparam int unsigned NCB_ADDR_MAX = 2047;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_LOAD = 4'b0010,
    S_REQ  = 4'b0100,
    S_WAIT = 4'b1000
  } state_t;

  typedef struct packed {
    logic [USER_W-1:0] user;
    logic [E01_W-1:0]  e01;
    logic [NCB_W-1:0]  ncb;
    logic              last;
  } job_t;

  // Ncb is counted in 16-entry units; the combine address space is 11 bits wide.
  function automatic logic ncb_ok(input logic [NCB_W-1:0] ncb);
    return (ncb[NCB_W-1:4] != '0) && (ncb[NCB_W-1:4] <= 12'(NCB_ADDR_MAX));
  endfunction

endpackage

// File: rtl/combine_job_scheduler_if.sv
// Job descriptor push interface: master is the slot/user configuration logic,
// slave is the scheduler.
interface combine_job_scheduler_if;
  import comb_sched_pkg::*;

  logic              i_job_valid;
  logic              o_job_ready;
  logic [USER_W-1:0] i_job_user_index;
  logic [E01_W-1:0]  i_job_e01_size;
  logic [NCB_W-1:0]  i_job_ncb_size;
  logic              i_job_last;

  modport master (
    output i_job_valid, i_job_user_index, i_job_e01_size, i_job_ncb_size, i_job_last,
    input  o_job_ready
  );

  modport slave (
    input  i_job_valid, i_job_user_index, i_job_e01_size, i_job_ncb_size, i_job_last,
    output o_job_ready
  );
endinterface

// File: rtl/combine_job_scheduler_fifo.sv
// Synchronous descriptor FIFO with flush; a push in the flush cycle lands in
// the emptied queue.
module comb_job_fifo
  import comb_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_flush,
  input  logic i_push,
  input  logic i_pop,
  input  job_t i_data,
  output job_t o_data,
  output logic o_full,
  output logic o_empty
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  job_t             r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_wr_idx;
  logic             w_push;
  logic             w_pop;

  assign o_full   = (r_count == CNT_W'(FIFO_DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_push   = i_push && !o_full;
  assign w_pop    = i_pop && !o_empty && !i_flush;
  assign w_wr_idx = i_flush ? '0 : r_wr;
  assign o_data   = r_mem[r_rd];

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[w_wr_idx] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= PTR_W'(w_push);
      r_count <= CNT_W'(w_push);
    end else begin
      r_wr    <= r_wr + PTR_W'(w_push);
      r_rd    <= r_rd + PTR_W'(w_pop);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

endmodule

// File: rtl/combine_job_scheduler.sv
// Queues per-code-block HARQ combine jobs and issues them one at a time to FSM_Combine.
// Define COMBINE_WATCHDOG_EN to add the WAIT_COMP watchdog and o_err_timeout.
module combine_job_scheduler
  import comb_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 8
`ifdef COMBINE_WATCHDOG_EN
  , parameter int unsigned WDOG_CYC = 65535
`endif
) (
  input  logic                     i_core_clk,
  input  logic                     i_rx_rst,
  input  logic                     i_slot_start,
  combine_job_scheduler_if.slave   job,
  output logic                     o_combine_process_request,
  output logic [USER_W-1:0]        o_combine_user_index,
  output logic [E01_W-1:0]         o_combine_e01_size,
  output logic [NCB_W-1:0]         o_combine_ncb_size,
  input  logic                     i_combine_comp,
  output logic                     o_combine_fsm_rstn,
  output logic                     o_busy,
  output logic [CNT_W-1:0]         o_jobs_done,
  output logic                     o_slot_done,
  output logic                     o_err_cfg,
  output logic                     o_err_overrun
`ifdef COMBINE_WATCHDOG_EN
  , output logic                   o_err_timeout
`endif
);

  state_t            r_state;
  logic              r_req;
  logic [USER_W-1:0] r_user;
  logic [E01_W-1:0]  r_e01;
  logic [NCB_W-1:0]  r_ncb;
  logic              r_cur_last;
  logic [CNT_W-1:0]  r_jobs_done;
  logic              r_slot_done;
  logic              r_err_cfg;
  logic              r_err_overrun;
  logic              r_last_pending;
  logic              r_discard;

  logic w_full;
  logic w_empty;
  logic w_ready;
  logic w_fire;
  logic w_reject;
  logic w_count_ok;
  job_t w_in;
  job_t w_head;

`ifdef COMBINE_WATCHDOG_EN
  localparam int unsigned      WD_W    = $clog2(WDOG_CYC + 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(WDOG_CYC - 1);
  logic [WD_W-1:0] r_wdog;
  logic            r_rstn;
  logic            r_err_timeout;
  assign o_combine_fsm_rstn = r_rstn;
  assign o_err_timeout      = r_err_timeout;
`else
  assign o_combine_fsm_rstn = 1'b1;
`endif

  assign w_ready         = !w_full;
  assign job.o_job_ready = w_ready;
  assign w_fire          = job.i_job_valid && w_ready;
  assign w_reject        = !ncb_ok(job.i_job_ncb_size);
  assign w_in            = '{user: job.i_job_user_index, e01: job.i_job_e01_size,
                             ncb: job.i_job_ncb_size, last: job.i_job_last};
  // A job still in flight when its slot is restarted belongs to no slot.
  assign w_count_ok      = !r_discard && !i_slot_start;

  comb_job_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_core_clk),
    .i_rst   (i_rx_rst),
    .i_flush (i_slot_start),
    .i_push  (w_fire && !w_reject),
    .i_pop   (r_state == S_LOAD),
    .i_data  (w_in),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge i_core_clk) begin
    if (i_rx_rst) begin
      r_state        <= S_IDLE;
      r_req          <= 1'b0;
      r_user         <= '0;
      r_e01          <= '0;
      r_ncb          <= '0;
      r_cur_last     <= 1'b0;
      r_jobs_done    <= '0;
      r_slot_done    <= 1'b0;
      r_err_cfg      <= 1'b0;
      r_err_overrun  <= 1'b0;
      r_last_pending <= 1'b0;
      r_discard      <= 1'b0;
`ifdef COMBINE_WATCHDOG_EN
      r_wdog         <= '0;
      r_rstn         <= 1'b1;
      r_err_timeout  <= 1'b0;
`endif
    end else begin
      r_req       <= 1'b0;
      r_slot_done <= 1'b0;
`ifdef COMBINE_WATCHDOG_EN
      r_rstn      <= 1'b1;
`endif
      if (i_slot_start) begin
        r_jobs_done    <= '0;
        r_err_cfg      <= 1'b0;
        r_last_pending <= 1'b0;
        r_err_overrun  <= (r_state != S_IDLE);
        if (r_state != S_IDLE) r_discard <= 1'b1;
`ifdef COMBINE_WATCHDOG_EN
        r_err_timeout  <= 1'b0;
`endif
      end
      // Rejection after the slot-start clear: a same-cycle job belongs to the new slot.
      if (w_fire && w_reject) begin
        r_err_cfg <= 1'b1;
        if (job.i_job_last) r_last_pending <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_discard <= 1'b0;
          if (r_last_pending && w_empty && !i_slot_start) begin
            r_slot_done    <= 1'b1;
            r_last_pending <= 1'b0;
          end
          if (!w_empty && !i_slot_start) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_user     <= w_head.user;
          r_e01      <= w_head.e01;
          r_ncb      <= w_head.ncb;
          r_cur_last <= w_head.last;
          r_req      <= 1'b1;
          r_state    <= S_REQ;
        end
        S_REQ: begin
          r_state <= S_WAIT;
`ifdef COMBINE_WATCHDOG_EN
          r_wdog  <= '0;
`endif
        end
        S_WAIT: begin
          if (i_combine_comp) begin
            r_state <= S_IDLE;
            if (w_count_ok) begin
              if (r_jobs_done != '1) r_jobs_done <= r_jobs_done + CNT_W'(1);
              if (r_cur_last) r_slot_done <= 1'b1;
            end
          end
`ifdef COMBINE_WATCHDOG_EN
          else if (r_wdog == WD_LAST) begin
            r_state       <= S_IDLE;
            r_rstn        <= 1'b0;
            r_err_timeout <= 1'b1;
            if (w_count_ok && r_cur_last) r_slot_done <= 1'b1;
          end else begin
            r_wdog <= r_wdog + WD_W'(1);
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_combine_process_request = r_req;
  assign o_combine_user_index      = r_user;
  assign o_combine_e01_size        = r_e01;
  assign o_combine_ncb_size        = r_ncb;
  assign o_busy                    = (r_state != S_IDLE) || !w_empty;
  assign o_jobs_done               = r_jobs_done;
  assign o_slot_done               = r_slot_done;
  assign o_err_cfg                 = r_err_cfg;
  assign o_err_overrun             = r_err_overrun;

endmodule

// File: tb/tb_combine_job_scheduler.sv
// Self-checking bench for combine_job_scheduler (default build, watchdog disabled).
module tb_combine_job_scheduler;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          slot_start;
  logic          comp;
  logic          req;
  logic [3:0]    o_user;
  logic [13:0]   o_e01;
  logic [15:0]   o_ncb;
  logic          rstn;
  logic          busy;
  logic [CW-1:0] jobs_done;
  logic          slot_done;
  logic          err_cfg;
  logic          err_overrun;

  always #5 clk = ~clk;

  combine_job_scheduler_if job_if();

  combine_job_scheduler #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .i_core_clk                (clk),
    .i_rx_rst                  (rst),
    .i_slot_start              (slot_start),
    .job                       (job_if),
    .o_combine_process_request (req),
    .o_combine_user_index      (o_user),
    .o_combine_e01_size        (o_e01),
    .o_combine_ncb_size        (o_ncb),
    .i_combine_comp            (comp),
    .o_combine_fsm_rstn        (rstn),
    .o_busy                    (busy),
    .o_jobs_done               (jobs_done),
    .o_slot_done               (slot_done),
    .o_err_cfg                 (err_cfg),
    .o_err_overrun             (err_overrun)
  );

  typedef struct {
    logic [3:0]  user;
    logic [13:0] e01;
    logic [15:0] ncb;
  } cfg_t;

  typedef struct {
    logic [3:0]  user;
    logic [13:0] e01;
    logic [15:0] ncb;
    logic        last;
    logic        exp_req;
    logic        exp_err_cfg;
    logic        exp_slot_done;
    logic [7:0]  exp_jobs_done;
  } vec_t;

  cfg_t sb[$];
  cfg_t cur;
  cfg_t e_mon;
  logic inflight = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_req = 0;
  int   n_slot_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: each request must match the oldest expected job; config must hold until comp.
  always @(negedge clk) begin
    if (req) begin
      n_req++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_req: request for user %0d, none expected", o_user);
      end else begin
        e_mon = sb.pop_front();
        chk("req_user", 32'(o_user), 32'(e_mon.user));
        chk("req_e01", 32'(o_e01), 32'(e_mon.e01));
        chk("req_ncb", 32'(o_ncb), 32'(e_mon.ncb));
        cur      = e_mon;
        inflight = 1'b1;
      end
    end
    if (comp && inflight) begin
      chk("held_cfg", {12'd0, o_user, o_ncb}, {12'd0, cur.user, cur.ncb});
      chk("held_e01", 32'(o_e01), 32'(cur.e01));
      inflight = 1'b0;
    end
    if (slot_done) n_slot_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    slot_start = 1'b1;
    tick();
    slot_start = 1'b0;
  endtask

  task automatic pulse_comp();
    comp = 1'b1;
    tick();
    comp = 1'b0;
  endtask

  task automatic push_job(input logic [3:0] user, input logic [13:0] e01,
                          input logic [15:0] ncb, input logic last, input bit expect_issue);
    int w;
    job_if.i_job_valid      = 1'b1;
    job_if.i_job_user_index = user;
    job_if.i_job_e01_size   = e01;
    job_if.i_job_ncb_size   = ncb;
    job_if.i_job_last       = last;
    w = 0;
    while (!job_if.o_job_ready && w < 50) begin
      tick();
      w++;
    end
    if (!job_if.o_job_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_wait: ready stuck low for user %0d", user);
    end else begin
      if (expect_issue) sb.push_back('{user: user, e01: e01, ncb: ncb});
      tick();
    end
    job_if.i_job_valid = 1'b0;
  endtask

  task automatic wait_req(input int base);
    int w;
    w = 0;
    while (n_req <= base && w < 60) begin
      tick();
      w++;
    end
    chk("req_seen", 32'(n_req > base), 32'd1);
  endtask

  vec_t vecs[7];
  int   lat;
  int   req0;
  int   sd0;

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{user: 4'd3, e01: 14'd1000,  ncb: 16'd1024,   last: 1'b1, exp_req: 1'b1, exp_err_cfg: 1'b0, exp_slot_done: 1'b1, exp_jobs_done: 8'd1};
    vecs[1] = '{user: 4'd5, e01: 14'd16383, ncb: 16'h7FF0,   last: 1'b1, exp_req: 1'b1, exp_err_cfg: 1'b0, exp_slot_done: 1'b1, exp_jobs_done: 8'd1};
    vecs[2] = '{user: 4'd1, e01: 14'd1,     ncb: 16'h0010,   last: 1'b0, exp_req: 1'b1, exp_err_cfg: 1'b0, exp_slot_done: 1'b0, exp_jobs_done: 8'd1};
    vecs[3] = '{user: 4'd4, e01: 14'd100,   ncb: 16'd8,      last: 1'b1, exp_req: 1'b0, exp_err_cfg: 1'b1, exp_slot_done: 1'b1, exp_jobs_done: 8'd0};
    vecs[4] = '{user: 4'd6, e01: 14'd200,   ncb: 16'h8000,   last: 1'b1, exp_req: 1'b0, exp_err_cfg: 1'b1, exp_slot_done: 1'b1, exp_jobs_done: 8'd0};
    vecs[5] = '{user: 4'd7, e01: 14'd300,   ncb: 16'h000F,   last: 1'b0, exp_req: 1'b0, exp_err_cfg: 1'b1, exp_slot_done: 1'b0, exp_jobs_done: 8'd0};
    vecs[6] = '{user: 4'd15, e01: 14'd77,   ncb: 16'hFFF0,   last: 1'b1, exp_req: 1'b0, exp_err_cfg: 1'b1, exp_slot_done: 1'b1, exp_jobs_done: 8'd0};

    rst = 1'b1;
    slot_start = 1'b0;
    comp = 1'b0;
    job_if.i_job_valid = 1'b0;
    job_if.i_job_user_index = '0;
    job_if.i_job_e01_size = '0;
    job_if.i_job_ncb_size = '0;
    job_if.i_job_last = 1'b0;
    tickn(3);
    chk("rst_ready", 32'(job_if.o_job_ready), 32'd1);
    chk("rst_rstn", 32'(rstn), 32'd1);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_jobs_done", 32'(jobs_done), 32'd0);
    chk("rst_flags", {29'd0, slot_done, err_cfg, err_overrun}, 32'd0);
    chk("rst_cfg", {12'd0, o_user, o_ncb}, 32'd0);
    rst = 1'b0;
    tick();

    // Single-job vectors; latency counts cycles from the push cycle (push cycle = 0).
    foreach (vecs[k]) begin
      pulse_start();
      req0 = n_req;
      push_job(vecs[k].user, vecs[k].e01, vecs[k].ncb, vecs[k].last, vecs[k].exp_req);
      chk("v_err_cfg", 32'(err_cfg), 32'(vecs[k].exp_err_cfg));
      if (vecs[k].exp_req) begin
        lat = 1;
        while (!req && lat < 10) begin
          tick();
          lat++;
        end
        chk("v_latency", 32'(lat), 32'd3);
        tickn(36);
        chk("v_busy", 32'(busy), 32'd1);
        pulse_comp();
        chk("v_jobs_done", 32'(jobs_done), 32'(vecs[k].exp_jobs_done));
        chk("v_slot_done", 32'(slot_done), 32'(vecs[k].exp_slot_done));
        tick();
        chk("v_slot_done_pulse", 32'(slot_done), 32'd0);
      end else begin
        tick();
        chk("v_slot_done", 32'(slot_done), 32'(vecs[k].exp_slot_done));
        tickn(8);
        chk("v_jobs_done", 32'(jobs_done), 32'(vecs[k].exp_jobs_done));
      end
      chk("v_req_count", 32'(n_req - req0), 32'(vecs[k].exp_req));
    end

    // Burst of 9 at depth 8: job 0 goes in flight, jobs 1..8 fill the queue.
    pulse_start();
    req0 = n_req;
    sd0  = n_slot_done;
    for (int i = 0; i < 9; i++)
      push_job(4'(i), 14'(10 * i + 5), 16'h0100 + 16'(i << 4), 1'(i == 8), 1'b1);
    chk("burst_ready_low", 32'(job_if.o_job_ready), 32'd0);
    for (int i = 0; i < 9; i++) begin
      wait_req(req0 + i);
      tickn(3);
      pulse_comp();
      chk("burst_jobs_done", 32'(jobs_done), 32'(i + 1));
    end
    tickn(5);
    chk("burst_slot_done_cnt", 32'(n_slot_done - sd0), 32'd1);
    chk("burst_idle", 32'(busy), 32'd0);

    // Overrun: slot start while a job waits for comp with 3 more queued.
    pulse_start();
    req0 = n_req;
    sd0  = n_slot_done;
    push_job(4'd10, 14'd111, 16'h0200, 1'b0, 1'b1);
    push_job(4'd11, 14'd112, 16'h0210, 1'b0, 1'b0);
    push_job(4'd12, 14'd113, 16'h0220, 1'b0, 1'b0);
    push_job(4'd13, 14'd114, 16'h0230, 1'b1, 1'b0);
    wait_req(req0);
    tickn(2);
    pulse_start();
    chk("ovr_err", 32'(err_overrun), 32'd1);
    chk("ovr_busy", 32'(busy), 32'd1);
    chk("ovr_ready", 32'(job_if.o_job_ready), 32'd1);
    tickn(2);
    pulse_comp();
    chk("ovr_jobs_done", 32'(jobs_done), 32'd0);
    tickn(20);
    chk("ovr_req_count", 32'(n_req - req0), 32'd1);
    chk("ovr_slot_done_cnt", 32'(n_slot_done - sd0), 32'd0);
    chk("ovr_idle", 32'(busy), 32'd0);
    chk("ovr_sticky", 32'(err_overrun), 32'd1);

    // Spurious comps in IDLE and in LOAD.
    pulse_start();
    chk("start_clears_ovr", 32'(err_overrun), 32'd0);
    req0 = n_req;
    pulse_comp();
    tickn(4);
    chk("spur_idle_jobs", 32'(jobs_done), 32'd0);
    chk("spur_idle_req", 32'(n_req - req0), 32'd0);
    push_job(4'd9, 14'd55, 16'h0400, 1'b1, 1'b1);
    tick();
    pulse_comp();
    chk("spur_load_req", 32'(req), 32'd1);
    chk("spur_load_jobs", 32'(jobs_done), 32'd0);
    tickn(5);
    pulse_comp();
    chk("spur_real_jobs", 32'(jobs_done), 32'd1);
    chk("spur_real_slot_done", 32'(slot_done), 32'd1);
    tickn(3);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
